// File: rtl/alu_op_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_driver_if
// Desc     : Command, ALU-drive and response bundle for alu_op_driver.
//            master = driver side, slave = command source / ALU / sink side.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_op_driver_if;
  // command channel
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;
  // ALU drive and observation
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;
  // response channel
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_mismatch;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    input  alu_result, alu_carry, alu_zero,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_mismatch
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    output alu_result, alu_carry, alu_zero,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_mismatch
  );
endinterface
`default_nettype wire

// File: rtl/alu_op_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_driver
// Desc     : Drives a registered 4-bit ALU from a valid/ready command stream,
//            checks the ALU outputs against a golden model and returns the
//            captured result with a mismatch flag and a saturating error count.
// Optional : ALU_DRV_SELFTEST_EN enables the LFSR-driven self-test run.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_driver #(
  parameter int CNT_W        = 8,
  parameter int SELFTEST_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_op_driver_if.master  bus,
  input  logic             clear_count,
  output logic [CNT_W-1:0] err_count,
  input  logic             selftest_start,
  output logic             selftest_busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_CAPT    = 3'd2,
    S_RESP    = 3'd3,
    S_ST_EXEC = 3'd4,
    S_ST_CAPT = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [3:0]       g_a_q, g_a_d, g_b_q, g_b_d;
  logic [1:0]       g_op_q, g_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [3:0]       rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_mismatch_q, rsp_mismatch_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [4:0]       gold5;
  logic             mismatch;
  logic             err_inc;

`ifdef ALU_DRV_SELFTEST_EN
  localparam int OPW = $clog2(SELFTEST_LEN + 1);
  logic [7:0]     lfsr_q, lfsr_d;
  logic [OPW-1:0] st_cnt_q, st_cnt_d;

  // Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction
`else
  logic unused_selftest;
  assign unused_selftest = selftest_start ^ (SELFTEST_LEN == 0);
`endif

  // Golden model: 5-bit arithmetic so bit 4 is the carry/borrow
  always_comb begin
    gold5 = 5'd0;
    case (g_op_q)
      2'b00:   gold5 = {1'b0, g_a_q} + {1'b0, g_b_q};
      2'b01:   gold5 = {1'b0, g_a_q} - {1'b0, g_b_q};
      2'b10:   gold5 = {1'b0, g_a_q & g_b_q};
      default: gold5 = {1'b0, g_a_q | g_b_q};
    endcase
  end

  assign mismatch = (bus.alu_result != gold5[3:0]) ||
                    (bus.alu_carry  != gold5[4])   ||
                    (bus.alu_zero   != (gold5[3:0] == 4'd0));

  // Next-state, operand, response and counter logic
  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    g_a_d          = g_a_q;
    g_b_d          = g_b_q;
    g_op_d         = g_op_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_mismatch_d = rsp_mismatch_q;
    err_inc        = 1'b0;
`ifdef ALU_DRV_SELFTEST_EN
    lfsr_d         = lfsr_q;
    st_cnt_d       = st_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef ALU_DRV_SELFTEST_EN
        // self-test wins over a simultaneous command; first op uses the seed
        if (selftest_start) begin
          alu_a_d  = 4'h5;
          alu_b_d  = 4'hA;
          alu_op_d = 2'b00;
          g_a_d    = 4'h5;
          g_b_d    = 4'hA;
          g_op_d   = 2'b00;
          lfsr_d   = lfsr_step(8'hA5);
          st_cnt_d = '0;
          state_d  = S_ST_EXEC;
        end else
`endif
        if (bus.cmd_valid) begin
          alu_a_d  = bus.cmd_a;
          alu_b_d  = bus.cmd_b;
          alu_op_d = bus.cmd_op;
          g_a_d    = bus.cmd_a;
          g_b_d    = bus.cmd_b;
          g_op_d   = bus.cmd_op;
          state_d  = S_EXEC;
        end
      end
      // ALU registers its result at the end of this cycle
      S_EXEC: state_d = S_CAPT;
      S_CAPT: begin
        rsp_result_d   = bus.alu_result;
        rsp_carry_d    = bus.alu_carry;
        rsp_zero_d     = bus.alu_zero;
        rsp_mismatch_d = mismatch;
        rsp_valid_d    = 1'b1;
        err_inc        = mismatch;
        state_d        = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
`ifdef ALU_DRV_SELFTEST_EN
      S_ST_EXEC: state_d = S_ST_CAPT;
      S_ST_CAPT: begin
        err_inc  = mismatch;
        alu_a_d  = lfsr_q[3:0];
        alu_b_d  = lfsr_q[7:4];
        alu_op_d = alu_op_q + 2'd1;
        g_a_d    = lfsr_q[3:0];
        g_b_d    = lfsr_q[7:4];
        g_op_d   = alu_op_q + 2'd1;
        lfsr_d   = lfsr_step(lfsr_q);
        st_cnt_d = st_cnt_q + OPW'(1);
        state_d  = (st_cnt_q == OPW'(SELFTEST_LEN - 1)) ? S_IDLE : S_ST_EXEC;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // clear beats a same-cycle increment; the count saturates at all-ones
    if (clear_count)
      err_d = '0;
    else if (err_inc && (err_q != {CNT_W{1'b1}}))
      err_d = err_q + CNT_W'(1);
    else
      err_d = err_q;
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      g_a_q          <= '0;
      g_b_q          <= '0;
      g_op_q         <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_mismatch_q <= 1'b0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      g_a_q          <= g_a_d;
      g_b_q          <= g_b_d;
      g_op_q         <= g_op_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_mismatch_q <= rsp_mismatch_d;
      err_q          <= err_d;
    end
  end

`ifdef ALU_DRV_SELFTEST_EN
  // Self-test pattern generator and op counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= 8'hA5;
      st_cnt_q <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign selftest_busy = (state_q == S_ST_EXEC) || (state_q == S_ST_CAPT);
`else
  assign selftest_busy = 1'b0;
`endif

  assign bus.cmd_ready    = (state_q == S_IDLE);
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_carry    = rsp_carry_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_mismatch = rsp_mismatch_q;
  assign err_count        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_driver
// Desc     : Directed, table-driven bench for alu_op_driver with a registered
//            4-bit ALU stand-in that supports result/carry fault injection.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_driver;
  localparam int CNT_W        = 8;
  localparam int SELFTEST_LEN = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear_count;
  logic [CNT_W-1:0] err_count;
  logic             selftest_start;
  logic             selftest_busy;

  logic [3:0] fault_mask;
  logic       stuck_carry;
  logic [4:0] alu_full;
  logic [3:0] alu_r_q = 4'd0;
  logic       alu_c_q = 1'b0;
  logic       alu_z_q = 1'b0;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] fmask;
    int         hold;
    logic [3:0] r;
    logic       c;
    logic       z;
    logic       m;
  } vec_t;

  vec_t vecs[7];

  alu_op_driver_if bus ();

  alu_op_driver #(
    .CNT_W        (CNT_W),
    .SELFTEST_LEN (SELFTEST_LEN)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .clear_count    (clear_count),
    .err_count      (err_count),
    .selftest_start (selftest_start),
    .selftest_busy  (selftest_busy)
  );

  always #5 clk = ~clk;

  // Registered ALU stand-in; zero flag reflects the unfaulted result
  always_comb begin
    alu_full = 5'd0;
    case (bus.alu_op)
      2'b00:   alu_full = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      2'b01:   alu_full = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      2'b10:   alu_full = {1'b0, bus.alu_a & bus.alu_b};
      default: alu_full = {1'b0, bus.alu_a | bus.alu_b};
    endcase
  end

  // One-cycle ALU latency with fault injection
  always @(posedge clk) begin
    alu_r_q <= alu_full[3:0] & ~fault_mask;
    alu_c_q <= alu_full[4] & ~stuck_carry;
    alu_z_q <= (alu_full[3:0] == 4'd0);
  end

  assign bus.alu_result = alu_r_q;
  assign bus.alu_carry  = alu_c_q;
  assign bus.alu_zero   = alu_z_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One command through the driver; clr pulses clear_count into the capture edge
  task automatic run_vec(input vec_t v, input bit chk, input bit clr);
    int lat;
    fault_mask    = v.fmask;
    bus.cmd_a     = v.a;
    bus.cmd_b     = v.b;
    bus.cmd_op    = v.op;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    if (chk) begin
      check("cmd_ready_after_accept", bus.cmd_ready, 0);
      check("alu_a_driven", bus.alu_a, v.a);
      check("alu_b_driven", bus.alu_b, v.b);
      check("alu_op_driven", bus.alu_op, v.op);
    end
    while (!bus.rsp_valid && lat < 8) begin
      if (clr && lat == 2) clear_count = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    clear_count = 1'b0;
    if (clr) exp_err = 0;
    else if (v.m && exp_err < 255) exp_err++;
    if (chk) begin
      check("latency", lat, 3);
      check("rsp_result", bus.rsp_result, v.r);
      check("rsp_carry", bus.rsp_carry, v.c);
      check("rsp_zero", bus.rsp_zero, v.z);
      check("rsp_mismatch", bus.rsp_mismatch, v.m);
      check("err_count", err_count, exp_err);
      for (int i = 0; i < v.hold; i++) begin
        @(posedge clk); #1;
        check("bp_rsp_valid", bus.rsp_valid, 1);
        check("bp_rsp_result", bus.rsp_result, v.r);
        check("bp_rsp_flags", {bus.rsp_carry, bus.rsp_zero, bus.rsp_mismatch}, {v.c, v.z, v.m});
        check("bp_cmd_ready", bus.cmd_ready, 0);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    if (chk) begin
      check("rsp_valid_drop", bus.rsp_valid, 0);
      check("cmd_ready_return", bus.cmd_ready, 1);
    end
  endtask

`ifdef ALU_DRV_SELFTEST_EN
  task automatic run_selftest(output int busy_cyc, output bit saw_valid, output bit saw_ready);
    selftest_start = 1'b1;
    @(posedge clk); #1;
    selftest_start = 1'b0;
    busy_cyc  = 0;
    saw_valid = 1'b0;
    saw_ready = 1'b0;
    while (selftest_busy && busy_cyc < 200) begin
      busy_cyc++;
      saw_valid = saw_valid | bus.rsp_valid;
      saw_ready = saw_ready | bus.cmd_ready;
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    int  bc;
    bit  sv, sr;
    bit  seen;

    //          a     b     op     fmask hold r     c     z     m
    vecs[0] = '{4'h9, 4'h8, 2'b00, 4'h0, 0,   4'h1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'h3, 4'h5, 2'b01, 4'h0, 0,   4'hE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'h5, 4'h5, 2'b01, 4'h0, 0,   4'h0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{4'hF, 4'h3, 2'b10, 4'h2, 0,   4'h1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'hA, 4'h5, 2'b11, 4'h0, 5,   4'hF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{4'hF, 4'h1, 2'b00, 4'h0, 0,   4'h0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{4'hA, 4'h5, 2'b10, 4'h0, 0,   4'h0, 1'b0, 1'b1, 1'b0};

    rst_n          = 1'b0;
    clear_count    = 1'b0;
    selftest_start = 1'b0;
    fault_mask     = 4'h0;
    stuck_carry    = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_a      = 4'h0;
    bus.cmd_b      = 4'h0;
    bus.cmd_op     = 2'b00;
    bus.rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_alu_ops", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
    check("rst_rsp_fields", {bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_mismatch}, 0);
    check("rst_err_count", err_count, 0);
    check("rst_selftest_busy", selftest_busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b1, 1'b0);

    // drive the counter into saturation, then confirm it sticks
    for (int i = 0; i < 260; i++) run_vec(vecs[3], 1'b0, 1'b0);
    check("err_saturated", err_count, 255);
    run_vec(vecs[3], 1'b1, 1'b0);
    run_vec(vecs[3], 1'b1, 1'b1);
    run_vec(vecs[3], 1'b1, 1'b0);

    // reset while the command sits in CAPT
    fault_mask    = 4'h0;
    bus.cmd_a     = 4'hC;
    bus.cmd_b     = 4'h3;
    bus.cmd_op    = 2'b00;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_err = 0;
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_alu_ops", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
    check("midrst_err_count", err_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | bus.rsp_valid;
    end
    check("midrst_no_response", seen, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 1);

`ifdef ALU_DRV_SELFTEST_EN
    run_selftest(bc, sv, sr);
    check("st_busy_cycles", bc, 2 * SELFTEST_LEN);
    check("st_no_rsp_valid", sv, 0);
    check("st_cmd_ready_low", sr, 0);
    check("st_clean_err", err_count, exp_err);
    check("st_idle_after", bus.cmd_ready, 1);
    stuck_carry = 1'b1;
    run_selftest(bc, sv, sr);
    stuck_carry = 1'b0;
    check("st_fault_busy_cycles", bc, 2 * SELFTEST_LEN);
    check("st_fault_err_nonzero", (err_count != 0), 1);
`else
    selftest_start = 1'b1;
    @(posedge clk); #1;
    selftest_start = 1'b0;
    check("nost_busy", selftest_busy, 0);
    check("nost_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;
    check("nost_busy_later", selftest_busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
